div_ctrl: RTL and testbench

EX-stage controller for the multi-cycle divider. It accepts DIV and DIVU from EX and stalls the pipeline while the divider runs. It holds the divider's operands stable, handles pipeline flushes, and commits the quotient and remainder to the architectural HI/LO registers, which it owns along with the MTHI/MTLO write path. It sits between the EX stage and `div`, driving `div`'s start/annul/operand inputs and consuming its result/ready outputs.

---
 rtl/div_ctrl_pkg.sv | 30 +++
 rtl/div_ctrl_hilo_reg.sv | 51 +++++
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and types for the EX-stage divider controller.
//   - FSM state encodings (legacy 2-bit constants)
//   - divider start level encodings and the zero word
//   - packed layout of the 64-bit divider result
package div_ctrl_pkg;

  localparam int DATA_W = 32;

  // Controller FSM encodings
  localparam logic [1:0] STATE_IDLE  = 2'b00;
  localparam logic [1:0] STATE_BUSY  = 2'b01;
  localparam logic [1:0] STATE_DONE  = 2'b10;
  localparam logic [1:0] STATE_FLUSH = 2'b11;

  // Levels on the divider start input
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

  // Cycles spent in FLUSH with start low so the divider drains back to free
  localparam logic [1:0] FLUSH_CYCLES = 2'd2;

  // Divider result: remainder in the upper word, quotient in the lower word
  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
  } div_result_t;

endpackage

// File: rtl/div_ctrl_hilo_reg.sv
// hilo_reg: architectural HI/LO registers.
//   clk, rst          clock, synchronous active-high reset
//   commit            divider commit strobe (writes both HI and LO)
//   commit_hi/lo      divider remainder / quotient
//   mthi_we, mtlo_we  MTHI / MTLO write enables
//   mt_wdata          MTHI / MTLO write data
//   hi, lo            current HI / LO values
// A divider commit wins over MTHI/MTLO landing on the same edge; the move
// that loses is dropped, each register decided independently.
module hilo_reg
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [DATA_W-1:0] commit_hi,
  input  logic [DATA_W-1:0] commit_lo,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] mt_wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // HI register: divider commit first, then MTHI
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZERO_WORD;
    end else if (commit) begin
      hi <= commit_hi;
    end else if (mthi_we) begin
      hi <= mt_wdata;
    end else begin
      hi <= hi;
    end
  end

  // LO register: divider commit first, then MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= ZERO_WORD;
    end else if (commit) begin
      lo <= commit_lo;
    end else if (mtlo_we) begin
      lo <= mt_wdata;
    end else begin
      lo <= lo;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage controller for the multi-cycle divider.
//   clk, rst                     clock, synchronous active-high reset
//   ex_div_valid_i               DIV/DIVU present in EX
//   ex_div_signed_i              1 = DIV, 0 = DIVU
//   ex_op1_i, ex_op2_i           dividend / divisor from EX
//   flush_i                      pipeline flush, kills the EX instruction
//   stall_in_i                   later stage stalling, EX cannot advance
//   mthi_we_i, mtlo_we_i         MTHI / MTLO write enables
//   mt_wdata_i                   MTHI / MTLO write data
//   div_result_i, div_ready_i    divider result {rem, quot} and ready
//   stallreq_o                   stall request to pipeline control
//   div_signed_o, div_op1_o/op2  latched divider operands
//   div_start_o, div_annul_o     divider start level / cancel
//   hi_o, lo_o                   architectural HI / LO
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_valid_i,
  input  logic              ex_div_signed_i,
  input  logic [DATA_W-1:0] ex_op1_i,
  input  logic [DATA_W-1:0] ex_op2_i,
  input  logic              flush_i,
  input  logic              stall_in_i,
  input  logic              mthi_we_i,
  input  logic              mtlo_we_i,
  input  logic [DATA_W-1:0] mt_wdata_i,
  input  logic [63:0]       div_result_i,
  input  logic              div_ready_i,
  output logic              stallreq_o,
  output logic              div_signed_o,
  output logic [DATA_W-1:0] div_op1_o,
  output logic [DATA_W-1:0] div_op2_o,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [1:0]  flush_cnt;
  div_result_t result;

  logic accept;
  logic capture;
  logic commit;
  logic stall_req;
  logic annul;

  // Next-state and per-cycle control decode
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    stall_req  = 1'b0;
    annul      = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (ex_div_valid_i && !flush_i) begin
          accept     = 1'b1;
          stall_req  = 1'b1;
          next_state = STATE_BUSY;
        end else begin
          next_state = STATE_IDLE;
        end
      end
      STATE_BUSY: begin
        if (flush_i) begin
          annul      = 1'b1;
          stall_req  = 1'b1;
          next_state = STATE_FLUSH;
        end else if (div_ready_i) begin
          // Release the pipeline in the ready cycle itself
          capture    = 1'b1;
          next_state = STATE_DONE;
        end else begin
          stall_req  = 1'b1;
          next_state = STATE_BUSY;
        end
      end
      STATE_DONE: begin
        // ex_div_valid_i is the same instruction still sitting in EX: ignored
        if (flush_i) begin
          next_state = STATE_IDLE;
        end else if (!stall_in_i) begin
          commit     = 1'b1;
          next_state = STATE_IDLE;
        end else begin
          next_state = STATE_DONE;
        end
      end
      STATE_FLUSH: begin
        // A new divide may already be waiting; it is accepted once back in IDLE
        stall_req = ex_div_valid_i && !flush_i;
        if (flush_cnt == (FLUSH_CYCLES - 2'd1)) begin
          next_state = STATE_IDLE;
        end else begin
          next_state = STATE_FLUSH;
        end
      end
      default: begin
        next_state = STATE_IDLE;
      end
    endcase
  end

  // Outputs are held at zero while reset is asserted, even before the first edge
  assign stallreq_o  = stall_req & ~rst;
  assign div_annul_o = annul & ~rst;
  assign div_start_o = ((state == STATE_BUSY) && !rst) ? DIV_START : DIV_STOP;

  // State register and FLUSH drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_IDLE;
      flush_cnt <= 2'd0;
    end else begin
      state <= next_state;
      if ((state == STATE_FLUSH) && (next_state == STATE_FLUSH)) begin
        flush_cnt <= flush_cnt + 2'd1;
      end else begin
        flush_cnt <= 2'd0;
      end
    end
  end

  // Operand latch: the divider re-reads these at its sign-fix step, so they
  // only change on accept and stay frozen for the whole BUSY period
  always_ff @(posedge clk) begin
    if (rst) begin
      div_signed_o <= 1'b0;
      div_op1_o    <= ZERO_WORD;
      div_op2_o    <= ZERO_WORD;
    end else if (accept) begin
      div_signed_o <= ex_div_signed_i;
      div_op1_o    <= ex_op1_i;
      div_op2_o    <= ex_op2_i;
    end else begin
      div_signed_o <= div_signed_o;
      div_op1_o    <= div_op1_o;
      div_op2_o    <= div_op2_o;
    end
  end

  // Result register, loaded in the divider-ready cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (capture) begin
      result <= div_result_i;
    end else begin
      result <= result;
    end
  end

  hilo_reg u_hilo_reg (
    .clk       (clk),
    .rst       (rst),
    .commit    (commit),
    .commit_hi (result.rem),
    .commit_lo (result.quot),
    .mthi_we   (mthi_we_i),
    .mtlo_we   (mtlo_we_i),
    .mt_wdata  (mt_wdata_i),
    .hi        (hi_o),
    .lo        (lo_o)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider.
// Stimulus pushes hand-computed {HI,LO} expectations; a monitor pops one
// whenever HI/LO change and compares.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_valid_i, ex_div_signed_i;
  logic [31:0] ex_op1_i, ex_op2_i;
  logic        flush_i, stall_in_i, mthi_we_i, mtlo_we_i;
  logic [31:0] mt_wdata_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o, div_signed_o, div_start_o, div_annul_o;
  logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_div_valid_i(ex_div_valid_i), .ex_div_signed_i(ex_div_signed_i),
    .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i),
    .flush_i(flush_i), .stall_in_i(stall_in_i),
    .mthi_we_i(mthi_we_i), .mtlo_we_i(mtlo_we_i), .mt_wdata_i(mt_wdata_i),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Behavioural divider: {rem, quot}, zero result on divide by zero
  function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  int mcnt;
  // Ready rises 35 cycles after start first goes high (3 for divide by zero)
  always @(posedge clk) begin
    if (rst || !div_start_o || div_annul_o) begin
      mcnt        <= 0;
      div_ready_i <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 >= ((div_op2_o == 32'd0) ? 3 : 35)) begin
        div_ready_i  <= 1'b1;
        div_result_i <= div_calc(div_signed_o, div_op1_o, div_op2_o);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every HI/LO change must match the oldest expectation
  initial begin
    logic [63:0] prev;
    prev = 64'h0;
    forever begin
      @(negedge clk);
      if (!rst && ({hi_o, lo_o} != prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL hilo_unexpected: got %h expected no update", {hi_o, lo_o});
        end else begin
          check("hilo_commit", {hi_o, lo_o}, exp_q.pop_front());
        end
        prev = {hi_o, lo_o};
      end
    end
  end

  // Count stalled cycles from the current negedge until stallreq drops
  task automatic wait_ready(input int exp_stall);
    int n;
    n = 0;
    while (n < 200 && stallreq_o) begin
      n++;
      @(negedge clk); #1;
    end
    check("stall_cycles", n, exp_stall);
    check("ready_start_high", div_start_o, 1'b1);
  endtask

  // From the ready cycle: DONE handling per mode
  // 0 normal, 2 stall_in 3 cycles in DONE, 3 flush in DONE, 4 MTHI same cycle + MTLO next
  task automatic finish_div(input int mode, input logic [31:0] ehi, input logic [31:0] elo);
    if (mode == 2) stall_in_i = 1'b1;
    @(negedge clk); #1;
    check("done_start_low", div_start_o, 1'b0);
    check("done_stallreq_low", stallreq_o, 1'b0);
    case (mode)
      2: begin
        repeat (3) begin
          @(negedge clk); #1;
          check("hold_start_low", div_start_o, 1'b0);
        end
        stall_in_i = 1'b0;
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        ex_div_valid_i = 1'b0;
      end
      3: begin
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        ex_div_valid_i = 1'b0;
      end
      4: begin
        mthi_we_i = 1'b1;
        mt_wdata_i = 32'hDEAD_BEEF;
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        ex_div_valid_i = 1'b0;
        mthi_we_i = 1'b0;
        mtlo_we_i = 1'b1;
        mt_wdata_i = 32'h0000_0055;
        exp_q.push_back({ehi, 32'h0000_0055});
        @(negedge clk);
        mtlo_we_i = 1'b0;
      end
      default: begin
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        ex_div_valid_i = 1'b0;
      end
    endcase
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input logic [31:0] ehi, input logic [31:0] elo,
                         input int exp_busy);
    @(negedge clk);
    ex_div_valid_i = 1'b1; ex_div_signed_i = sgn; ex_op1_i = a; ex_op2_i = b;
    #1;
    check("issue_stallreq", stallreq_o, 1'b1);
    check("issue_start_low", div_start_o, 1'b0);
    @(negedge clk); #1;
    check("busy_start", div_start_o, 1'b1);
    check("latched_op1", div_op1_o, a);
    check("latched_op2", div_op2_o, b);
    check("latched_signed", div_signed_o, sgn);
    // EX operands change under the stall; the latched copy must not follow
    ex_op1_i = ~a;
    ex_op2_i = b + 32'd1;
    wait_ready(exp_busy - 1);
    finish_div(mode, ehi, elo);
  endtask

  initial begin
    rst = 1'b1;
    ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b1;
    ex_op1_i = 32'd100; ex_op2_i = 32'd7;
    flush_i = 1'b0; stall_in_i = 1'b0; mthi_we_i = 1'b0; mtlo_we_i = 1'b0;
    mt_wdata_i = 32'd0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_op1", div_op1_o, 32'd0);
    check("rst_op2", div_op2_o, 32'd0);
    check("rst_signed", div_signed_o, 1'b0);
    check("rst_start", div_start_o, 1'b0);
    check("rst_annul", div_annul_o, 1'b0);
    check("rst_stallreq", stallreq_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ex_div_valid_i = 1'b0;

    // DIVU 100/7 -> HI=2, LO=14
    run_div(1'b0, 32'd100, 32'd7, 0, 32'd2, 32'd14, 36);
    // DIV -7/2 -> HI=-1, LO=-3
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 36);
    // DIV 5/0 -> HI=LO=0, ready 3 cycles after start
    run_div(1'b1, 32'd5, 32'd0, 0, 32'd0, 32'd0, 4);

    // Flush 10 cycles into BUSY, then DIVU 9/4 -> HI=1, LO=2
    @(negedge clk);
    ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b0; ex_op1_i = 32'd64; ex_op2_i = 32'd5;
    #1;
    check("flush_issue_stallreq", stallreq_o, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    check("pre_flush_annul", div_annul_o, 1'b0);
    flush_i = 1'b1;
    #1;
    check("flush_annul", div_annul_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    ex_op1_i = 32'd9; ex_op2_i = 32'd4;
    #1;
    check("flush1_annul_low", div_annul_o, 1'b0);
    check("flush1_start", div_start_o, 1'b0);
    check("flush1_stallreq", stallreq_o, 1'b1);
    @(negedge clk); #1;
    check("flush2_start", div_start_o, 1'b0);
    @(negedge clk); #1;
    check("post_flush_idle_start", div_start_o, 1'b0);
    wait_ready(36);
    check("post_flush_op1", div_op1_o, 32'd9);
    finish_div(0, 32'd1, 32'd2);

    // DIVU 20/6 with stall_in held 3 cycles in DONE -> HI=2, LO=3, single commit
    run_div(1'b0, 32'd20, 32'd6, 2, 32'd2, 32'd3, 36);
    // DIVU 50/7 flushed in DONE -> no commit
    run_div(1'b0, 32'd50, 32'd7, 3, 32'd0, 32'd0, 36);
    // DIVU 8/3 with MTHI in the commit cycle -> HI=2, LO=2; then MTLO 0x55
    run_div(1'b0, 32'd8, 32'd3, 4, 32'd2, 32'd2, 36);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_hi", hi_o, 32'd2);
    check("final_lo", lo_o, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
